// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
package hazard_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    ST_RUN           = 2'b00,
    ST_MEM_WAIT      = 2'b01,
    ST_REDIRECT_PEND = 2'b10,
    ST_ERROR         = 2'b11
  } ctrl_state_e;

  // A load in E feeding either D-stage source; x0 is never a real dependency.
  function automatic logic load_use(input logic                  load_e,
                                    input logic [REG_ADDR_W-1:0] rd_e,
                                    input logic [REG_ADDR_W-1:0] rs1_d,
                                    input logic [REG_ADDR_W-1:0] rs2_d);
    return load_e && (rd_e != REG_ZERO) && ((rd_e == rs1_d) || (rd_e == rs2_d));
  endfunction

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Hazard-unit signal bundle; STALL_PERF_EN adds the performance counter outputs.
interface hazard_stall_controller_if;
  import hazard_pkg::*;

  logic                  LoadE;
  logic [REG_ADDR_W-1:0] RD_E;
  logic [REG_ADDR_W-1:0] Rs1_D;
  logic [REG_ADDR_W-1:0] Rs2_D;
  logic                  PCSrcE;
  logic                  DMemReqM;
  logic                  DMemReadyM;
  logic                  StallF;
  logic                  StallD;
  logic                  StallE;
  logic                  StallM;
  logic                  FlushD;
  logic                  FlushE;
  logic                  FlushW;
  logic                  MemTimeout;
  logic [1:0]            CtrlState;
`ifdef STALL_PERF_EN
  logic [31:0]           LuBubbles;
  logic [31:0]           MemWaitCycles;

  modport master (
    output LoadE, RD_E, Rs1_D, Rs2_D, PCSrcE, DMemReqM, DMemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           MemTimeout, CtrlState, LuBubbles, MemWaitCycles
  );
  modport slave (
    input  LoadE, RD_E, Rs1_D, Rs2_D, PCSrcE, DMemReqM, DMemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           MemTimeout, CtrlState, LuBubbles, MemWaitCycles
  );
`else
  modport master (
    output LoadE, RD_E, Rs1_D, Rs2_D, PCSrcE, DMemReqM, DMemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           MemTimeout, CtrlState
  );
  modport slave (
    input  LoadE, RD_E, Rs1_D, Rs2_D, PCSrcE, DMemReqM, DMemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           MemTimeout, CtrlState
  );
`endif

endinterface

// File: rtl/hazard_stall_controller_mem_wait_timer.sv
// Saturating data-memory wait counter with timeout detection.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Flags the wait cycle whose increment brings the count to MEM_TIMEOUT.
  assign expired = inc && (cnt >= CNT_LAST);

endmodule

// File: rtl/hazard_stall_controller.sv
// Stall/flush sequencer for load-use, data-memory waits (with timeout) and redirects.
// Optional macro STALL_PERF_EN adds LuBubbles/MemWaitCycles counters.
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  hazard_stall_controller_if.slave  hz
);

  ctrl_state_e state, state_next;
  logic lu, mw;
  logic tmr_clr, tmr_inc, tmr_expired;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w, mem_timeout;

  assign lu = load_use(hz.LoadE, hz.RD_E, hz.Rs1_D, hz.Rs2_D);
  assign mw = hz.DMemReqM && !hz.DMemReadyM;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .inc     (tmr_inc),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    tmr_clr     = 1'b0;
    tmr_inc     = 1'b0;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    stall_m     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    flush_w     = 1'b0;
    mem_timeout = 1'b0;
    // Outputs are combinational, so reset must mask them explicitly.
    if (rst) begin
      unique case (state)
        ST_RUN: begin
          if (mw) begin
            {stall_f, stall_d, stall_e, stall_m, flush_w} = '1;
            tmr_inc    = 1'b1;
            state_next = hz.PCSrcE ? ST_REDIRECT_PEND : ST_MEM_WAIT;
          end else if (hz.PCSrcE) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
          end else if (lu) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end
        end
        ST_MEM_WAIT, ST_REDIRECT_PEND: begin
          if (!hz.DMemReadyM) begin
            {stall_f, stall_d, stall_e, stall_m, flush_w} = '1;
            tmr_inc = 1'b1;
            if (tmr_expired) begin
              state_next = ST_ERROR;
            end
          end else begin
            tmr_clr    = 1'b1;
            state_next = ST_RUN;
            // A pending redirect was latched on entry; E stayed frozen since.
            if (state == ST_REDIRECT_PEND || hz.PCSrcE) begin
              flush_d = 1'b1;
              flush_e = 1'b1;
            end else if (lu) begin
              stall_f = 1'b1;
              stall_d = 1'b1;
              flush_e = 1'b1;
            end
          end
        end
        ST_ERROR: begin
          {stall_f, stall_d, stall_e, stall_m, flush_w, mem_timeout} = '1;
        end
        default: state_next = ST_RUN;
      endcase
    end
  end

  assign hz.StallF     = stall_f;
  assign hz.StallD     = stall_d;
  assign hz.StallE     = stall_e;
  assign hz.StallM     = stall_m;
  assign hz.FlushD     = flush_d;
  assign hz.FlushE     = flush_e;
  assign hz.FlushW     = flush_w;
  assign hz.MemTimeout = mem_timeout;
  assign hz.CtrlState  = rst ? state : ST_RUN;

`ifdef STALL_PERF_EN
  logic        lu_bubble;
  logic [31:0] lu_bubbles, mem_wait_cycles;

  // In RUN, StallD without StallM can only be the load-use bubble.
  assign lu_bubble = (state == ST_RUN) && stall_d && !stall_m;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lu_bubbles      <= '0;
      mem_wait_cycles <= '0;
    end else begin
      if (lu_bubble) lu_bubbles <= lu_bubbles + 32'd1;
      if (stall_m)   mem_wait_cycles <= mem_wait_cycles + 32'd1;
    end
  end

  assign hz.LuBubbles     = lu_bubbles;
  assign hz.MemWaitCycles = mem_wait_cycles;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller against an abstract pipeline-hazard model.
module tb_hazard_stall_controller;

  localparam int unsigned TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_stall_controller_if u_if ();

  hazard_stall_controller #(
    .MEM_TIMEOUT (TMO),
    .CNT_W       (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (u_if.slave)
  );

  typedef struct {
    bit waiting;
    bit redirect;
    bit error;
    int waited;
  } mdl_t;

  typedef struct {
    string      name;
    logic [9:0] v;
  } exp_t;

  exp_t  exp_q[$];
  mdl_t  m;
  int    checks = 0;
  int    errors = 0;
  bit    release_pending = 1'b0;
  int    lu_cnt = 0;
  int    mw_cnt = 0;

  function automatic logic [9:0] actual();
    return {u_if.StallF, u_if.StallD, u_if.StallE, u_if.StallM, u_if.FlushD,
            u_if.FlushE, u_if.FlushW, u_if.MemTimeout, u_if.CtrlState};
  endfunction

  // Expected outputs {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,MemTimeout,CtrlState}.
  function automatic void model(input mdl_t s, input bit le, input logic [4:0] rd,
                                input logic [4:0] r1, input logic [4:0] r2,
                                input bit pc, input bit req, input bit rdy,
                                output logic [9:0] e, output mdl_t n, output bit bub);
    bit lu, mw;
    bit sf, sd, se, sm, fd, fe, fw, to;
    logic [1:0] cs;
    lu = le && (rd != 5'd0) && (rd == r1 || rd == r2);
    mw = req && !rdy;
    n = s;
    bub = 1'b0;
    {sf, sd, se, sm, fd, fe, fw, to} = '0;
    cs = s.error ? 2'd3 : (s.waiting ? (s.redirect ? 2'd2 : 2'd1) : 2'd0);
    if (s.error) begin
      {sf, sd, se, sm, fw, to} = '1;
    end else if (s.waiting && !rdy) begin
      {sf, sd, se, sm, fw} = '1;
      n.waited = s.waited + 1;
      if (n.waited >= int'(TMO)) begin
        n.error   = 1'b1;
        n.waiting = 1'b0;
      end
    end else if (s.waiting && s.redirect) begin
      fd = 1'b1;
      fe = 1'b1;
      n.waiting = 1'b0; n.redirect = 1'b0; n.waited = 0;
    end else if (!s.waiting && mw) begin
      {sf, sd, se, sm, fw} = '1;
      n.waiting = 1'b1; n.redirect = pc; n.waited = 1;
    end else begin
      if (s.waiting) begin
        n.waiting = 1'b0; n.waited = 0;
      end
      if (pc) begin
        fd = 1'b1;
        fe = 1'b1;
      end else if (lu) begin
        sf = 1'b1; sd = 1'b1; fe = 1'b1;
        bub = !s.waiting;
      end
    end
    e = {sf, sd, se, sm, fd, fe, fw, to, cs};
  endfunction

  task automatic check_now(input string nm, input logic [9:0] act, input logic [9:0] e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, e);
    end
  endtask

  task automatic push(input string nm, input logic [9:0] v);
    exp_t x;
    x.name = nm;
    x.v    = v;
    exp_q.push_back(x);
  endtask

  task automatic step(input string nm, input bit le, input logic [4:0] rd, input logic [4:0] r1,
                      input logic [4:0] r2, input bit pc, input bit req, input bit rdy);
    logic [9:0] e;
    mdl_t n;
    bit b;
    @(posedge clk);
    #1;
    if (release_pending) begin
      rst = 1'b1;
      release_pending = 1'b0;
    end
    u_if.LoadE = le; u_if.RD_E = rd; u_if.Rs1_D = r1; u_if.Rs2_D = r2;
    u_if.PCSrcE = pc; u_if.DMemReqM = req; u_if.DMemReadyM = rdy;
    model(m, le, rd, r1, r2, pc, req, rdy, e, n, b);
    push(nm, e);
    m = n;
    if (b) lu_cnt++;
    if (e[6]) mw_cnt++;
  endtask

  // Asynchronous reset between clock edges; outputs must drop before the next edge.
  task automatic do_reset(input string nm);
    logic [9:0] e;
    mdl_t n;
    bit b;
    @(posedge clk);
    #1;
    if (rst) begin
      model(m, u_if.LoadE, u_if.RD_E, u_if.Rs1_D, u_if.Rs2_D, u_if.PCSrcE,
            u_if.DMemReqM, u_if.DMemReadyM, e, n, b);
      check_now({nm, "_pre"}, actual(), e);
    end
    rst = 1'b0;
    #1;
    check_now({nm, "_async"}, actual(), 10'd0);
    push({nm, "_hold0"}, 10'd0);
    m = '{default: 0};
    lu_cnt = 0;
    mw_cnt = 0;
    @(posedge clk);
    #1;
    push({nm, "_hold1"}, 10'd0);
`ifdef STALL_PERF_EN
    checks++;
    if (u_if.LuBubbles !== 32'd0 || u_if.MemWaitCycles !== 32'd0) begin
      errors++;
      $display("FAIL perf_reset: got %0d/%0d expected 0/0", u_if.LuBubbles, u_if.MemWaitCycles);
    end
`endif
    release_pending = 1'b1;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check_now(x.name, actual(), x.v);
      end
    end
  end

  initial begin : stimulus
    u_if.LoadE = 1'b0; u_if.RD_E = '0; u_if.Rs1_D = '0; u_if.Rs2_D = '0;
    u_if.PCSrcE = 1'b0; u_if.DMemReqM = 1'b0; u_if.DMemReadyM = 1'b0;
    m = '{default: 0};
    do_reset("init");

    step("lu",        1, 5'd5, 5'd5, 5'd1, 0, 0, 0);
    step("lu_after",  0, 5'd5, 5'd5, 5'd1, 0, 0, 0);
    step("lu_x0",     1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step("lu_rs2",    1, 5'd9, 5'd1, 5'd9, 0, 0, 0);

    for (int i = 0; i < 3; i++) step("mw_wait", 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    step("mw_ready",  0, 5'd0, 5'd0, 5'd0, 0, 1, 1);
    step("mw_after",  0, 5'd0, 5'd0, 5'd0, 0, 0, 0);

    step("br_lu",     1, 5'd5, 5'd5, 5'd7, 1, 0, 0);

    step("br_mw",     0, 5'd0, 5'd0, 5'd0, 1, 1, 0);
    step("br_wait",   0, 5'd0, 5'd0, 5'd0, 1, 1, 0);
    step("br_wait",   0, 5'd0, 5'd0, 5'd0, 1, 1, 0);
    step("br_redir",  1, 5'd3, 5'd3, 5'd0, 0, 1, 1);
    step("br_after",  0, 5'd0, 5'd0, 5'd0, 0, 0, 0);

    step("mwx_lu_in", 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    step("mwx_lu",    1, 5'd4, 5'd0, 5'd4, 0, 1, 1);

    for (int i = 0; i < 5; i++) step("tmo_wait", 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    for (int i = 0; i < 2; i++) step("tmo_hold", 0, 5'd0, 5'd0, 5'd0, 1, 1, 1);
    do_reset("tmo_rst");

    step("mid_enter", 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    step("mid_wait",  0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    do_reset("mid_wait");
    step("perf_lu",   1, 5'd5, 5'd5, 5'd1, 0, 0, 0);
    step("perf_idle", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
`ifdef STALL_PERF_EN
    @(posedge clk);
    #1;
    checks++;
    if (u_if.LuBubbles !== 32'd1) begin
      errors++;
      $display("FAIL perf_lu1: got %0d expected 1", u_if.LuBubbles);
    end
`endif

    for (int i = 0; i < 3000; i++) begin
      if ((m.error && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
        do_reset("rnd_rst");
      end else begin
        step("rnd", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
             1'($urandom_range(0, 1)));
      end
    end

    step("final_idle", 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
`ifdef STALL_PERF_EN
    @(posedge clk);
    #1;
    checks++;
    if (u_if.LuBubbles !== 32'(lu_cnt) || u_if.MemWaitCycles !== 32'(mw_cnt)) begin
      errors++;
      $display("FAIL perf_totals: got %0d/%0d expected %0d/%0d",
               u_if.LuBubbles, u_if.MemWaitCycles, lu_cnt, mw_cnt);
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
